// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer controller: default
// sizing and the state encoding used by the controller FSM.
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SPR_W_DEF      = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_baud_gen.sv
// Baud clock generator: a prescale counter and a toggle flop. Each half
// period lasts 2^spr_q system clocks, and every period starts with its low
// half. While run is low, everything is held cleared, so the baud clock is
// always 0 outside a transfer.
module spi_baud_gen import spi_pkg::*; #(
  parameter int SPR_W = SPR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [SPR_W-1:0] spr_q,
  output logic             M_BaudRate,
  output logic             fall_tick
);

  localparam int PRE_W = (2 ** SPR_W) - 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W:0]   half_len;
  logic [PRE_W-1:0] half_last;
  logic             half_end;

  assign half_len  = (PRE_W+1)'(1) << spr_q;
  assign half_last = PRE_W'(half_len - (PRE_W+1)'(1));
  assign half_end  = run && (pre_cnt == half_last);
  assign fall_tick = half_end && M_BaudRate;

  // Count clocks in the current half; flip the baud clock when the half ends.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pre_cnt    <= '0;
      M_BaudRate <= 1'b0;
    end else if (half_end) begin
      pre_cnt    <= '0;
      M_BaudRate <= ~M_BaudRate;
    end else begin
      pre_cnt    <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transfer controller. It sequences IDLE -> LOAD -> XFER -> DONE
// around the shifter, produces exactly DATA_WIDTH baud periods, and keeps
// the SPIF / WCOL status flags.
module spi_master_ctrl import spi_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SPR_W      = SPR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SPE,
  input  logic             MSTR,
  input  logic [SPR_W-1:0] SPR,
  input  logic             start,
  input  logic             SPIF_clr,
  output logic             M_BaudRate,
  output logic             idle,
  output logic             shifter_en,
  output logic             SPDR_rd_en,
  output logic             SPDR_wr_en,
  output logic             SPIF,
  output logic             WCOL,
  output logic             busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [SPR_W-1:0] spr_q;
  logic [BIT_W-1:0] bit_cnt;
  logic             accept;
  logic             run;
  logic             fall_tick;
  logic             last_fall;
  logic             spif_set;
  logic             wcol_set;

  assign accept    = (state == S_IDLE) && start && SPE && MSTR;
  assign run       = (state == S_XFER) && SPE;
  assign last_fall = fall_tick && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign spif_set  = (state == S_DONE) && SPE;
  assign wcol_set  = start && (state != S_IDLE);

  spi_baud_gen #(
    .SPR_W (SPR_W)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .spr_q      (spr_q),
    .M_BaudRate (M_BaudRate),
    .fall_tick  (fall_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and shifter/SCK handshake outputs; losing SPE aborts to IDLE.
  always_comb begin
    state_next = state;
    idle       = 1'b1;
    shifter_en = 1'b0;
    SPDR_rd_en = 1'b0;
    SPDR_wr_en = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        SPDR_rd_en = 1'b1;
        busy       = 1'b0;
        if (accept) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        SPDR_rd_en = 1'b1;
        shifter_en = 1'b1;
        state_next = SPE ? S_XFER : S_IDLE;
      end
      S_XFER: begin
        idle       = 1'b0;
        shifter_en = 1'b1;
        if (!SPE) begin
          state_next = S_IDLE;
        end else if (last_fall) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        SPDR_wr_en = SPE;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Latch the baud select at start and count completed baud periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      spr_q   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      spr_q   <= SPR;
      bit_cnt <= '0;
    end else if (fall_tick) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Status flags; a set on the same edge as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      SPIF <= 1'b0;
      WCOL <= 1'b0;
    end else begin
      if (spif_set) begin
        SPIF <= 1'b1;
      end else if (SPIF_clr || accept) begin
        SPIF <= 1'b0;
      end
      if (wcol_set) begin
        WCOL <= 1'b1;
      end else if (SPIF_clr) begin
        WCOL <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl. Each accepted start pushes the expected
// transfer outcome (DONE cycle, XFER length, baud periods, half length)
// into a scoreboard; a negedge monitor measures the real transfer and
// compares when SPDR_wr_en appears. Directed checks cover reset, collision,
// abort, guards and flag priority; a randomized loop covers varied baud rates.
module tb_spi_master_ctrl;

  localparam int DW    = 8;
  localparam int SPR_W = 3;

  typedef struct {
    int done_cyc;
    int xfer_len;
    int periods;
    int half;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             SPE;
  logic             MSTR;
  logic [SPR_W-1:0] SPR;
  logic             start;
  logic             SPIF_clr;
  logic             M_BaudRate;
  logic             idle;
  logic             shifter_en;
  logic             SPDR_rd_en;
  logic             SPDR_wr_en;
  logic             SPIF;
  logic             WCOL;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  // Monitor bookkeeping
  int   xfer_len, rises, run_len, half_min, half_max;
  logic in_xfer = 1'b0;
  logic prev_m  = 1'b0;
  logic spif_due = 1'b0;

  spi_master_ctrl #(
    .DATA_WIDTH (DW),
    .SPR_W      (SPR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SPE        (SPE),
    .MSTR       (MSTR),
    .SPR        (SPR),
    .start      (start),
    .SPIF_clr   (SPIF_clr),
    .M_BaudRate (M_BaudRate),
    .idle       (idle),
    .shifter_en (shifter_en),
    .SPDR_rd_en (SPDR_rd_en),
    .SPDR_wr_en (SPDR_wr_en),
    .SPIF       (SPIF),
    .WCOL       (WCOL),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noteHalf(input int len);
    if (len < half_min) half_min = len;
    if (len > half_max) half_max = len;
  endtask

  // Pulse start for one cycle with the given baud select; if the transfer
  // should complete, push its expected outcome. Returns in the LOAD cycle.
  task automatic applyStimulus(input int spr, input bit expect_done, output int c0);
    exp_t e;
    int   len;
    SPR   = SPR_W'(spr);
    start = 1'b1;
    c0    = cyc;
    if (expect_done) begin
      len        = DW * (2 ** (spr + 1));
      e.done_cyc = c0 + 2 + len;
      e.xfer_len = len;
      e.periods  = DW;
      e.half     = 2 ** spr;
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    SPR   = SPR_W'($urandom_range(0, 7));
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput("wait_idle_timeout", busy, 0);
  endtask

  task automatic clearFlags();
    SPIF_clr = 1'b1;
    tick();
    SPIF_clr = 1'b0;
    checkOutput("flags_cleared", {SPIF, WCOL}, 0);
  endtask

  // Scoreboard monitor: measure each transfer and compare at SPDR_wr_en.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (shifter_en && SPDR_rd_en) begin
        xfer_len = 0;
        rises    = 0;
        run_len  = 0;
        half_min = 1 << 30;
        half_max = 0;
        in_xfer  = 1'b0;
        prev_m   = 1'b0;
      end
      if (spif_due) begin
        checkOutput("spif_after_done", SPIF, 1);
        spif_due = 1'b0;
      end
      if (!idle) begin
        if (!in_xfer) begin
          run_len = 1;
        end else if (M_BaudRate != prev_m) begin
          noteHalf(run_len);
          run_len = 1;
        end else begin
          run_len++;
        end
        if (M_BaudRate && !prev_m) rises++;
        xfer_len++;
        in_xfer = 1'b1;
        prev_m  = M_BaudRate;
      end else begin
        if (in_xfer) noteHalf(run_len);
        in_xfer = 1'b0;
        prev_m  = 1'b0;
      end
      if (SPDR_wr_en) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_wr_en", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", cyc, e.done_cyc);
          checkOutput("xfer_len", xfer_len, e.xfer_len);
          checkOutput("baud_periods", rises, e.periods);
          checkOutput("half_min", half_min, e.half);
          checkOutput("half_max", half_max, e.half);
        end
        spif_due = 1'b1;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and randomized stimulus.
  initial begin
    int c0;
    int c1;
    rst = 1'b1; SPE = 1'b1; MSTR = 1'b1; SPR = '0; start = 1'b0; SPIF_clr = 1'b0;

    // Reset values.
    tick();
    tick();
    checkOutput("reset_outputs",
                {M_BaudRate, idle, shifter_en, SPDR_rd_en, SPDR_wr_en, SPIF, WCOL, busy},
                8'b0101_0000);
    rst = 1'b0;
    tick();

    // Nominal transfer, SPR=0.
    applyStimulus(0, 1'b1, c0);
    checkOutput("load_outputs", {shifter_en, SPDR_rd_en, idle, busy}, 4'b1111);
    tick();
    checkOutput("xfer_entry", {idle, M_BaudRate, shifter_en, SPDR_rd_en}, 4'b0010);
    waitIdle(100);
    checkOutput("nominal_spif_cycle", cyc - c0, 19);
    clearFlags();

    // Collision at cycle 10, SPIF_clr at cycle 25.
    applyStimulus(0, 1'b1, c0);
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("wcol_set", WCOL, 1);
    waitIdle(100);
    checkOutput("collision_spif_cycle", cyc - c0, 19);
    checkOutput("collision_flags", {SPIF, WCOL}, 2'b11);
    repeat (6) tick();
    clearFlags();

    // Slow baud, SPR=3.
    applyStimulus(3, 1'b1, c0);
    waitIdle(300);
    checkOutput("slow_spif_delay", cyc - c0, 131);
    checkOutput("slow_spif", SPIF, 1);
    clearFlags();

    // Abort with SPE=0 at cycle 8; a collision at cycle 4 sets WCOL first.
    applyStimulus(0, 1'b0, c0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    SPE = 1'b0;
    tick();
    checkOutput("abort_idle", {idle, M_BaudRate, busy, shifter_en}, 4'b1000);
    SPE = 1'b1;
    repeat (30) tick();
    checkOutput("abort_flags_kept", {SPIF, WCOL}, 2'b01);
    clearFlags();

    // Guards: MSTR=0 or SPE=0 block a start, with no flag change.
    MSTR  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("mstr_guard", {busy, SPIF, WCOL, SPDR_rd_en}, 4'b0001);
    MSTR  = 1'b1;
    SPE   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("spe_guard", {busy, SPIF, WCOL}, 3'b000);
    SPE = 1'b1;

    // SPIF_clr in DONE loses to the set; then a back-to-back start.
    applyStimulus(0, 1'b1, c0);
    repeat (17) tick();
    checkOutput("done_wr_en", SPDR_wr_en, 1);
    SPIF_clr = 1'b1;
    tick();
    SPIF_clr = 1'b0;
    checkOutput("spif_set_wins", SPIF, 1);
    applyStimulus(1, 1'b1, c1);
    checkOutput("b2b_spif_cleared", SPIF, 0);
    checkOutput("b2b_load", {shifter_en, SPDR_rd_en}, 2'b11);
    waitIdle(100);
    clearFlags();

    // Reset mid-transfer.
    applyStimulus(2, 1'b1, c0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checkOutput("reset_mid_xfer",
                {M_BaudRate, idle, shifter_en, SPDR_rd_en, SPDR_wr_en, SPIF, WCOL, busy},
                8'b0101_0000);
    sb.delete();
    spif_due = 1'b0;
    rst = 1'b0;
    tick();

    // Randomized transfers with optional collisions and SPR changes.
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(0, 4), 1'b1, c0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 5)) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("wcol_random", WCOL, 1);
      end
      waitIdle(600);
      checkOutput("spif_random", SPIF, 1);
      clearFlags();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
